apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_master.sv | 107 ++++++++++
 tb/tb_apb_master.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
//==============================================================================
// Module   : apb_master
// Purpose  : Single-target APB master. A read or write command issued in IDLE
//            runs one APB transfer (SETUP then ACCESS until pready) to the
//            fixed address ADDR. Read data is kept in rdata_q; a write sends
//            rdata_q + 1.
// Ports    : pclk_i    - clock, rising edge
//            prst_n    - synchronous reset, active high
//            req_i     - command: 01 read, 10 write, 00/11 no-op
//            prdata_i  - APB read data
//            pready_i  - APB ready
//            psel_o    - APB select
//            penable_o - APB enable
//            paddr_o   - APB address (ADDR while busy, 0 in IDLE)
//            pwrite_o  - APB direction, 1 = write
//            pwdata_o  - APB write data (rdata_q + 1 during a write)
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module apb_master #(
  parameter logic [31:0] ADDR = 32'hDEAD_CAFE
) (
  input  logic        pclk_i,
  input  logic        prst_n,
  input  logic [1:0]  req_i,
  input  logic [31:0] prdata_i,
  input  logic        pready_i,
  output logic        psel_o,
  output logic        penable_o,
  output logic [31:0] paddr_o,
  output logic        pwrite_o,
  output logic [31:0] pwdata_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam logic [1:0] c_REQ_READ  = 2'b01;
  localparam logic [1:0] c_REQ_WRITE = 2'b10;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_write;     // latched command: 1 = write, 0 = read
  logic [31:0] r_rdata_q;   // last completed read data
  logic [31:0] r_pwdata;    // write data frozen at SETUP entry
  logic        w_start;
  logic        w_busy;

  // Commands are only accepted from IDLE; 00 and 11 are no-ops.
  assign w_start = (r_state == IDLE) &&
                   ((req_i == c_REQ_READ) || (req_i == c_REQ_WRITE));

  // State register
  always_ff @(posedge pclk_i) begin
    if (prst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next_state = SETUP;
      SETUP:   w_next_state = ACCESS;
      ACCESS:  if (pready_i) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Command latch, read-data capture and write-data snapshot
  always_ff @(posedge pclk_i) begin
    if (prst_n) begin
      r_write   <= 1'b0;
      r_rdata_q <= 32'd0;
      r_pwdata  <= 32'd0;
    end else begin
      if (w_start) begin
        r_write  <= (req_i == c_REQ_WRITE);
        // Snapshot taken on IDLE->SETUP so the value cannot move mid-transfer
        // even if rdata_q were to change.
        r_pwdata <= (req_i == c_REQ_WRITE) ? (r_rdata_q + 32'd1) : 32'd0;
      end
      if ((r_state == ACCESS) && pready_i && !r_write) begin
        r_rdata_q <= prdata_i;
      end
    end
  end

  // Outputs decode purely from registered state, so pready_i/prdata_i never
  // reach an output combinationally.
  assign w_busy    = (r_state == SETUP) || (r_state == ACCESS);
  assign psel_o    = w_busy;
  assign penable_o = (r_state == ACCESS);
  assign paddr_o   = w_busy ? ADDR : 32'd0;
  assign pwrite_o  = w_busy && r_write;
  assign pwdata_o  = (w_busy && r_write) ? r_pwdata : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_apb_master.sv
//==============================================================================
// Module   : tb_apb_master
// Purpose  : Directed self-checking bench for apb_master.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_apb_master;

  localparam logic [31:0] c_ADDR = 32'hDEAD_CAFE;

  logic        pclk_i = 1'b0;
  logic        prst_n;
  logic [1:0]  req_i;
  logic [31:0] prdata_i;
  logic        pready_i;
  logic        psel_o;
  logic        penable_o;
  logic [31:0] paddr_o;
  logic        pwrite_o;
  logic [31:0] pwdata_o;

  int n_checks = 0;
  int n_errors = 0;

  apb_master #(.ADDR(c_ADDR)) dut (
    .pclk_i    (pclk_i),
    .prst_n    (prst_n),
    .req_i     (req_i),
    .prdata_i  (prdata_i),
    .pready_i  (pready_i),
    .psel_o    (psel_o),
    .penable_o (penable_o),
    .paddr_o   (paddr_o),
    .pwrite_o  (pwrite_o),
    .pwdata_o  (pwdata_o)
  );

  always #5 pclk_i = ~pclk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1 ns later.
  task automatic tick();
    @(posedge pclk_i);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".psel"},    {31'd0, psel_o},    32'd0);
    chk({tag, ".penable"}, {31'd0, penable_o}, 32'd0);
    chk({tag, ".paddr"},   paddr_o,            32'd0);
    chk({tag, ".pwrite"},  {31'd0, pwrite_o},  32'd0);
    chk({tag, ".pwdata"},  pwdata_o,           32'd0);
  endtask

  task automatic chk_busy(input string tag, input logic en, input logic wr,
                          input logic [31:0] wd);
    chk({tag, ".psel"},    {31'd0, psel_o},    32'd1);
    chk({tag, ".penable"}, {31'd0, penable_o}, {31'd0, en});
    chk({tag, ".paddr"},   paddr_o,            c_ADDR);
    chk({tag, ".pwrite"},  {31'd0, pwrite_o},  {31'd0, wr});
    chk({tag, ".pwdata"},  pwdata_o,           wd);
  endtask

  // One full transfer from IDLE: cmd issued for one edge, mid_req driven
  // during SETUP/ACCESS (must be ignored), pready low for `waits` ACCESS
  // cycles then high with prdata = rd.
  task automatic xfer(input string tag, input logic [1:0] cmd, input int waits,
                      input logic [31:0] rd, input logic [1:0] mid_req,
                      input logic wr, input logic [31:0] wd);
    req_i    = cmd;
    pready_i = 1'b0;
    prdata_i = rd;
    tick();
    req_i = mid_req;
    chk_busy({tag, ".setup"}, 1'b0, wr, wd);
    tick();
    for (int i = 0; i < waits; i++) begin
      chk_busy($sformatf("%s.wait%0d", tag, i), 1'b1, wr, wd);
      tick();
    end
    pready_i = 1'b1;
    chk_busy({tag, ".last"}, 1'b1, wr, wd);
    tick();
    req_i    = 2'b00;
    pready_i = 1'b0;
    chk_idle({tag, ".done"});
  endtask

  task automatic do_reset();
    prst_n = 1'b1;
    tick();
    tick();
    prst_n = 1'b0;
  endtask

  initial begin
    prst_n   = 1'b1;
    req_i    = 2'b00;
    prdata_i = 32'd0;
    pready_i = 1'b0;

    do_reset();
    chk_idle("reset");

    // Read: 3 wait cycles (4 ACCESS cycles), then write uses rdata+1.
    xfer("rd1234", 2'b01, 3, 32'h0000_1234, 2'b10, 1'b0, 32'd0);
    xfer("wr1235", 2'b10, 3, 32'hFFFF_0000, 2'b01, 1'b1, 32'h0000_1235);

    // Write right after reset: no prior read -> pwdata = 1, 2-cycle transfer.
    do_reset();
    chk_idle("reset2");
    xfer("wr_rst", 2'b10, 0, 32'h5555_5555, 2'b00, 1'b1, 32'h0000_0001);

    // Wrap-around.
    xfer("rdFFFF", 2'b01, 0, 32'hFFFF_FFFF, 2'b11, 1'b0, 32'd0);
    xfer("wrwrap", 2'b10, 1, 32'h0000_0007, 2'b01, 1'b1, 32'h0000_0000);

    // No-op commands keep the bus idle.
    for (int i = 0; i < 10; i++) begin
      req_i = (i < 5) ? 2'b00 : 2'b11;
      tick();
      chk($sformatf("noop%0d.psel", i), {31'd0, psel_o}, 32'd0);
    end
    req_i = 2'b00;

    // Command change mid-transfer does not alter the read; data still lands.
    xfer("rd_mid", 2'b01, 2, 32'h0000_0005, 2'b10, 1'b0, 32'd0);
    xfer("wr_mid", 2'b10, 2, 32'h0000_0000, 2'b01, 1'b1, 32'h0000_0006);

    // Reset in ACCESS with pready high: abort, no capture.
    req_i    = 2'b01;
    prdata_i = 32'h0000_AAAA;
    tick();
    req_i = 2'b00;
    chk_busy("abort.setup", 1'b0, 1'b0, 32'd0);
    tick();
    chk_busy("abort.access", 1'b1, 1'b0, 32'd0);
    pready_i = 1'b1;
    prst_n   = 1'b1;
    tick();
    prst_n   = 1'b0;
    pready_i = 1'b0;
    chk_idle("abort.after");
    xfer("wr_abort", 2'b10, 0, 32'h0000_AAAA, 2'b00, 1'b1, 32'h0000_0001);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
